s4_actividad1: RTL and testbench
================================

Name: s4_actividad1

Overview:
- Time-multiplexed driver for an 8-digit common-anode 7-segment display.
- Shows a 32-bit value as 8 hexadecimal digits, one nibble per digit, by cycling the active digit at a rate set by an internal prescaler.
- Sits between a data source (switches or a register) and the board's segment/anode pins.

Parameters:
- REFRESH_DIV, default 100000, clock cycles each digit stays active. Legal range is 1..2^24. The default gives a 1 kHz digit rate at 100 MHz.

Ports:
- clock  input  1  system clock; all state is updated on its rising edge.
- reset  input  1  synchronous, active-high reset.
- HEX_in  input  32  value to display; digit i shows HEX_in[4i+3:4i].
- segments  output  7  active-low cathodes, ordered {g,f,e,d,c,b,a}; bit 0 is segment a.
- anodes  output  8  active-low digit enables; bit i drives digit i (digit 0 is rightmost).

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Prescaler:
  - Counter runs 0..REFRESH_DIV-1 and wraps to 0.
  - A tick is asserted in the cycle where count == REFRESH_DIV-1.
  - With REFRESH_DIV=1, a tick occurs every cycle.
- Digit index:
  - 3-bit register, advances by 1 on each tick and wraps 7 -> 0.
- Output registers: every cycle not in reset,
  - anodes <= ~(8'b1 << idx).
  - segments <= decode(HEX_in[4*idx+3 -: 4]), where idx is the current (pre-update) index.
  - Exactly one anode is low at any time after the first post-reset edge.
- Latency:
  - Outputs follow the index and HEX_in with 1 cycle of latency.
  - A change on HEX_in appears on segments within 1 cycle, if its digit is active.
  - HEX_in is not latched; it is sampled every cycle.
- Reset (at any time, including mid-scan):
  - prescaler = 0, idx = 0, anodes = 8'hFF (all off), segments = 7'h7F (blank).
  - The first edge after reset deasserts gives anodes = 8'hFE and segments = decode(HEX_in[3:0]).
  - Digit 0 then stays active for exactly REFRESH_DIV cycles.
- Decode table, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- No leading-zero blanking: every digit is always displayed, including leading zeros.
- Wrap-around: after digit 7, digit 0 follows with no idle or blank cycle.

Test Plan:
- Reset values: hold reset=1 for 2 edges -> anodes=FF, segments=7F.
- Scan order (REFRESH_DIV=4, HEX_in=32'd123456=0x0001E240), release reset:
  - anodes steps FE, FD, FB, F7, EF, DF, BF, 7F, FE, each held 4 cycles.
  - segments follows 40(0), 19(4), 24(2), 06(E), 79(1), 40, 40, 40, then repeats.
- Decoder sweep: REFRESH_DIV=1, HEX_in=0x76543210 then 0xFEDCBA98 -> each digit's segments matches the table above; exactly one anode is low every cycle after the first.
- Live update: while digit 2 is active, change HEX_in[11:8] from 2 to 9 -> segments changes from 24 to 10 on the next edge; anodes is unchanged.
- Mid-scan reset: assert reset one cycle while digit 5 is active -> the next edge gives FF/7F; after release the scan restarts at digit 0 with a full REFRESH_DIV dwell.
- Degenerate divider: REFRESH_DIV=1 -> the digit advances every cycle and the index wraps 7 -> 0 with no gap.

Source files
------------

// File: rtl/s4_actividad1.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Each nibble of HEX_in is shown as a hex digit, one digit active at a time.
module s4_actividad1 #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] HEX_in,
  output logic [6:0]  segments,
  output logic [7:0]  anodes
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;
  logic             tick;
  logic [3:0]       nib;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = tick ? idx_q + 3'd1 : idx_q;
    // Outputs use the pre-update index; HEX_in is sampled live every cycle
    nib   = HEX_in[{idx_q, 2'b00} +: 4];
    an_d  = ~(8'b1 << idx_q);
    seg_d = decode_hex(nib);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign segments = seg_q;
  assign anodes   = an_q;

endmodule

// File: tb/tb_s4_actividad1.sv
// Self-checking bench: two drivers (divider 4 and 1) compared against a
// model that derives the displayed digit from the cycle count since reset.
module tb_s4_actividad1;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] HEX_in;
  logic [6:0]  seg4, seg1;
  logic [7:0]  an4, an1;

  always #5 clock = ~clock;

  s4_actividad1 #(.REFRESH_DIV(4)) dut4 (
    .clock(clock), .reset(reset), .HEX_in(HEX_in), .segments(seg4), .anodes(an4)
  );
  s4_actividad1 #(.REFRESH_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .HEX_in(HEX_in), .segments(seg1), .anodes(an1)
  );

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [31:0] hex_smp = '0;

  // Edges since reset released, and the HEX_in value seen at the last edge
  always @(posedge clock) begin
    if (reset) k = 0;
    else       k = k + 1;
    hex_smp = HEX_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  function automatic int digit_of(input int n);
    return ((k - 1) / n) % 8;
  endfunction

  function automatic logic [7:0] exp_an(input int n);
    logic [7:0] a;
    if (k == 0) return 8'hFF;
    a = 8'hFF;
    a[digit_of(n)] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_seg(input int n);
    logic [3:0] nibv;
    if (k == 0) return 7'h7F;
    nibv = hex_smp[4*digit_of(n) +: 4];
    return tbl[nibv];
  endfunction

  task automatic check_all();
    chk("an_div4", {24'h0, an4}, {24'h0, exp_an(4)});
    chk("seg_div4", {25'h0, seg4}, {25'h0, exp_seg(4)});
    chk("an_div1", {24'h0, an1}, {24'h0, exp_an(1)});
    chk("seg_div1", {25'h0, seg1}, {25'h0, exp_seg(1)});
    if (k > 0) begin
      chk("onehot_div4", $countones(~an4), 1);
      chk("onehot_div1", $countones(~an1), 1);
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_all();
  endtask

  initial begin
    bit found;
    reset  = 1'b1;
    HEX_in = 32'h0001E240;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_an", {24'h0, an4}, 32'hFF);
    chk("rst_seg", {25'h0, seg4}, 32'h7F);
    check_all();

    reset = 1'b0;
    step();
    chk("first_an", {24'h0, an4}, 32'hFE);
    chk("first_seg", {25'h0, seg4}, 32'h40);
    repeat (40) step();

    HEX_in = 32'h76543210;
    repeat (24) step();

    // Live update of digit 2 while it is being shown
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (digit_of(4) == 2 && ((k - 1) % 4) == 0) found = 1'b1;
    end
    chk("live_found", {31'h0, found}, 32'h1);
    chk("live_seg_before", {25'h0, seg4}, 32'h24);
    HEX_in[11:8] = 4'h9;
    step();
    chk("live_seg_after", {25'h0, seg4}, 32'h10);
    chk("live_an", {24'h0, an4}, 32'hFB);

    HEX_in = 32'hFEDCBA98;
    repeat (24) step();

    // Reset asserted for one cycle while digit 5 is active
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (digit_of(4) == 5) found = 1'b1;
    end
    chk("mid_found", {31'h0, found}, 32'h1);
    reset = 1'b1;
    step();
    chk("mid_rst_an", {24'h0, an4}, 32'hFF);
    chk("mid_rst_seg", {25'h0, seg4}, 32'h7F);
    reset = 1'b0;
    step();
    chk("mid_restart_an", {24'h0, an4}, 32'hFE);
    repeat (40) step();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) HEX_in = $urandom;
      reset = ($urandom_range(49) == 0);
      step();
    end
    reset = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
